mem_port_arbiter: RTL

Sequences the single shared memory port between the pipeline's instruction-fetch stage (IF) and data-memory stage (MEM) in the 5-stage MIPS CPU. It accepts held-level requests from both stages and runs one memory transaction at a time with a req/ack handshake. It returns read data and a one-cycle ack to the winning stage, and drives a pipeline stall while any request is unserved. Data accesses win over fetches, with alternation to prevent starvation; a saturating conflict counter supports performance debug.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the fetch (IF) and data (MEM) stages.
// One transaction at a time over a req/ack handshake; data wins ties and
// each requester waits at most one foreign transaction.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   if_req_i/if_addr_i              fetch request (held until if_ack_o)
//   if_ack_o/if_inst_o              one-cycle ack, registered fetched word
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request (held until d_ack_o)
//   d_ack_o/d_rdata_o               one-cycle ack, registered load data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request side
//   mem_ack_i/mem_rdata_i           memory completion and read data
//   grant_o                         owner: 01 fetch, 10 data, 00 none
//   stall_o                         any request not yet acknowledged
//   conflict_cnt_o                  saturating count of fetch-lost cycles
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_inst_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [1:0]    grant_o,
  output logic          stall_o,
  output logic [CW-1:0] conflict_cnt_o
);

  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, DONE_I, DONE_D} state_t;

  state_t state_q, state_d;
  logic   start_i, start_d, fetch_lost;

  // DONE_x hands the port straight to the other requester if it is waiting,
  // which is what bounds each side's wait to one foreign transaction.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (d_req_i) state_d = GNT_D;
               else if (if_req_i) state_d = GNT_I;
      GNT_I:   if (mem_ack_i) state_d = DONE_I;
      GNT_D:   if (mem_ack_i) state_d = DONE_D;
      DONE_I:  state_d = d_req_i ? GNT_D : IDLE;
      DONE_D:  state_d = if_req_i ? GNT_I : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start_i = (state_d == GNT_I) && (state_q != GNT_I);
  assign start_d = (state_d == GNT_D) && (state_q != GNT_D);

  // Fetch loses a cycle whenever both want the port and the FSM is in a
  // state where fetch cannot be the next grant.
  assign fetch_lost = if_req_i && d_req_i &&
                      (state_q == IDLE || state_q == DONE_I || state_q == GNT_D);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      if_inst_o      <= '0;
      d_rdata_o      <= '0;
      conflict_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      if (start_i) begin
        mem_addr_o <= if_addr_i;
        mem_we_o   <= 1'b0;
      end
      if (start_d) begin
        mem_addr_o  <= d_addr_i;
        mem_we_o    <= d_we_i;
        mem_wdata_o <= d_wdata_i;
      end
      if (state_q == GNT_I && mem_ack_i)
        if_inst_o <= mem_rdata_i;
      if (state_q == GNT_D && mem_ack_i && !mem_we_o)
        d_rdata_o <= mem_rdata_i;
      if (fetch_lost && conflict_cnt_o != {CW{1'b1}})
        conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end

  assign mem_req_o = (state_q == GNT_I) || (state_q == GNT_D);
  assign if_ack_o  = (state_q == DONE_I);
  assign d_ack_o   = (state_q == DONE_D);
  assign grant_o   = {(state_q == GNT_D) || (state_q == DONE_D),
                      (state_q == GNT_I) || (state_q == DONE_I)};
  assign stall_o   = !rst_i && ((if_req_i && !if_ack_o) || (d_req_i && !d_ack_o));

endmodule
